// File: rtl/fetch_unit_if.sv
// Fetch front-end bundle: instruction-memory request/response, execute redirect and decode output.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid never depends on ready.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    modport master (
        output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_addr, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_addr, out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch front-end: credit-limited word fetch, in-order PC tag FIFO, DEPTH-entry
// instruction queue, and redirect flush that discards responses still in flight.
module fetch_unit #(
    parameter logic [31:0] START_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 4
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   q_instr_q [DEPTH];
    logic [31:0]   q_instr_d [DEPTH];
    logic [31:0]   q_pc_q    [DEPTH];
    logic [31:0]   q_pc_d    [DEPTH];
    logic [31:0]   tag_q     [DEPTH];
    logic [31:0]   tag_d     [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic [CW-1:0] count_q, count_d, inflight_q, inflight_d, drop_q, drop_d;

    logic          req_fire, rsp_fire, push, pop;
    logic [CW:0]   credits_used;

    // Discarded in-flight words still hold credits, so the queue can never overflow.
    assign credits_used       = {1'b0, inflight_q} + {1'b0, count_q};
    assign bus.imem_req_valid = !rst && !bus.redirect_valid && (credits_used < DEPTH_W);
    assign bus.imem_req_addr  = pc_q;
    assign bus.out_valid      = (count_q != '0) && !bus.redirect_valid;
    assign bus.out_instr      = q_instr_q[rd_ptr_q];
    assign bus.out_pc         = q_pc_q[rd_ptr_q];

    always_comb begin
        req_fire   = bus.imem_req_valid && bus.imem_req_ready;
        rsp_fire   = bus.imem_rsp_valid && (inflight_q != '0);
        pop        = bus.out_valid && bus.out_ready;
        push       = rsp_fire && !bus.redirect_valid && (drop_q == '0);

        pc_d       = pc_q;
        q_instr_d  = q_instr_q;
        q_pc_d     = q_pc_q;
        tag_d      = tag_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        tag_rd_d   = tag_rd_q;
        tag_wr_d   = tag_wr_q;
        count_d    = count_q;
        drop_d     = drop_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_fire);

        // The tag FIFO tracks every outstanding request, dropped or not, so it is never flushed.
        if (req_fire) begin
            pc_d            = pc_q + 32'd4;
            tag_d[tag_wr_q] = pc_q;
            tag_wr_d        = tag_wr_q + 1'b1;
        end
        if (rsp_fire) begin
            tag_rd_d = tag_rd_q + 1'b1;
        end

        if (bus.redirect_valid) begin
            pc_d     = bus.redirect_addr & 32'hFFFF_FFFC;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            drop_d   = inflight_q - CW'(rsp_fire);
        end else begin
            if (rsp_fire && (drop_q != '0)) begin
                drop_d = drop_q - 1'b1;
            end
            if (push) begin
                q_instr_d[wr_ptr_q] = bus.imem_rsp_data;
                q_pc_d[wr_ptr_q]    = tag_q[tag_rd_q];
                wr_ptr_d            = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= START_ADDR;
            q_instr_q  <= '{default: '0};
            q_pc_q     <= '{default: '0};
            tag_q      <= '{default: '0};
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            q_instr_q  <= q_instr_d;
            q_pc_q     <= q_pc_d;
            tag_q      <= tag_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order variable-latency memory, epoch-tagged reference of the
// instruction stream decode must see, directed scenarios plus a long randomized run.
module tb_fetch_unit;
    localparam logic [31:0] START = 32'hFFFF_FFF8;
    localparam int          DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_unit_if bus();

    fetch_unit #(.START_ADDR(START), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mem_t;

    mem_t        mem_q[$];
    logic [63:0] exp_q[$];
    int          epoch, cyc, last_due, n_fires;
    logic [31:0] next_req_pc;
    int          n_vec, n_err;

    int          lat_lo, lat_hi, ready_pct, ordy_pct, redir_pct, spur_pct;
    logic        force_redir;
    logic [31:0] force_addr;

    logic        cap_redir, cap_req_fire, cap_req_valid, cap_rsp, cap_pop, cap_out_valid;
    logic [31:0] cap_redir_addr, cap_req_addr, cap_out_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mem_q.delete();
        exp_q.delete();
        epoch++;
        next_req_pc = START;
        last_due    = 0;
    endtask

    task automatic drive_idle();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = 32'h0;
        bus.out_ready      = 1'b0;
    endtask

    // One clock cycle: drive at negedge, compare against the model, advance the model at posedge.
    task automatic step();
        logic        exp_ov, exp_rv;
        logic [63:0] head;
        mem_t        m;
        int          lat;
        @(negedge clk);
        bus.imem_req_ready = ($urandom_range(99) < ready_pct);
        bus.out_ready      = ($urandom_range(99) < ordy_pct);
        if (force_redir) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_addr  = force_addr;
            force_redir        = 1'b0;
        end else if ($urandom_range(99) < redir_pct) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_addr  = $urandom;
        end else begin
            bus.redirect_valid = 1'b0;
            bus.redirect_addr  = $urandom;
        end
        cap_rsp = 1'b0;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(mem_q[0].addr);
            cap_rsp            = 1'b1;
        end else if (mem_q.size() == 0 && $urandom_range(99) < spur_pct) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = $urandom;
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end
        #1;
        exp_ov = (exp_q.size() != 0) && !bus.redirect_valid;
        exp_rv = !bus.redirect_valid && ((mem_q.size() + exp_q.size()) < DEPTH);
        check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
        if (exp_ov) begin
            head = exp_q[0];
            check("out_pc", bus.out_pc, head[63:32]);
            check("out_instr", bus.out_instr, head[31:0]);
        end
        check("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
        check("req_addr", bus.imem_req_addr, next_req_pc);

        cap_redir      = bus.redirect_valid;
        cap_redir_addr = bus.redirect_addr;
        cap_req_valid  = bus.imem_req_valid;
        cap_req_fire   = bus.imem_req_valid && bus.imem_req_ready;
        cap_req_addr   = bus.imem_req_addr;
        cap_pop        = exp_ov && bus.out_ready;
        cap_out_valid  = bus.out_valid;
        cap_out_pc     = bus.out_pc;

        @(posedge clk);
        if (cap_rsp) m = mem_q.pop_front();
        if (cap_redir) begin
            exp_q.delete();
            epoch++;
            next_req_pc = cap_redir_addr & 32'hFFFF_FFFC;
        end else begin
            if (cap_pop) void'(exp_q.pop_front());
            if (cap_rsp && m.epoch == epoch) exp_q.push_back({m.addr, mem_word(m.addr)});
        end
        if (cap_req_fire) begin
            lat      = $urandom_range(lat_hi, lat_lo);
            last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            mem_q.push_back('{addr: cap_req_addr, epoch: epoch, due: last_due});
            n_fires++;
            if (!cap_redir) next_req_pc = next_req_pc + 32'd4;
        end
        cyc++;
    endtask

    task automatic set_knobs(input int llo, input int lhi, input int rdy, input int ordy,
                             input int rdr, input int spur);
        lat_lo = llo; lat_hi = lhi; ready_pct = rdy; ordy_pct = ordy; redir_pct = rdr; spur_pct = spur;
    endtask

    task automatic wait_first_pop(input string name, input logic [31:0] exp_pc);
        int k;
        k = 0;
        cap_pop = 1'b0;
        while (!cap_pop && k < 30) begin
            step();
            k++;
        end
        if (!cap_pop) check({name, "_timeout"}, 32'd0, 32'd1);
        else          check(name, cap_out_pc, exp_pc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        n_vec = 0; n_err = 0; epoch = 0; cyc = 0; n_fires = 0;
        force_redir = 1'b0; force_addr = 32'h0;
        drive_idle();
        model_reset();

        // Reset values
        #12;
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_req_addr", bus.imem_req_addr, START);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_instr", bus.out_instr, 32'd0);
        check("rst_out_pc", bus.out_pc, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Streaming from reset across the 32-bit PC wrap
        set_knobs(1, 1, 100, 100, 0, 0);
        step();
        check("a_req0_valid", 32'(cap_req_valid), 32'd1);
        check("a_req0_addr", cap_req_addr, 32'hFFFF_FFF8);
        step();
        check("a_req1_addr", cap_req_addr, 32'hFFFF_FFFC);
        step();
        check("a_pc0", cap_out_pc, 32'hFFFF_FFF8);
        check("a_req2_addr", cap_req_addr, 32'h0000_0000);
        step();
        check("a_pc1", cap_out_pc, 32'hFFFF_FFFC);
        step();
        check("a_pc2", cap_out_pc, 32'h0000_0000);
        repeat (6) step();

        // Decode stall: exactly DEPTH requests, then ordered drain and resume
        force_redir = 1'b1; force_addr = 32'h0000_0100; ordy_pct = 0;
        step();
        n0 = n_fires;
        repeat (12) step();
        check("b_fires_stalled", 32'(n_fires - n0), 32'd4);
        ordy_pct = 100;
        step();
        check("b_first_pc", cap_out_pc, 32'h0000_0100);
        check("b_resume_addr", cap_req_addr, 32'h0000_0110);
        repeat (6) step();

        // 3-cycle memory: redirect with two requests in flight
        set_knobs(3, 3, 100, 100, 0, 0);
        force_redir = 1'b1; force_addr = 32'h0000_0010;
        step();
        step();
        check("c_req_0x10", cap_req_addr, 32'h0000_0010);
        step();
        check("c_req_0x14", cap_req_addr, 32'h0000_0014);
        force_redir = 1'b1; force_addr = 32'h0000_2003;
        step();
        step();
        check("c_redir_addr", cap_req_addr, 32'h0000_2000);
        check("c_redir_valid", 32'(cap_req_valid), 32'd1);
        wait_first_pop("c_first_pc", 32'h0000_2000);
        repeat (6) step();

        // Redirect colliding with a response and a pop on a non-empty queue
        set_knobs(1, 1, 100, 100, 0, 0);
        repeat (5) step();
        force_redir = 1'b1; force_addr = 32'h0000_3001;
        step();
        check("d_no_out_in_redir", 32'(cap_out_valid), 32'd0);
        step();
        check("d_empty_after", 32'(cap_out_valid), 32'd0);
        check("d_new_addr", cap_req_addr, 32'h0000_3000);
        repeat (5) step();

        // Randomized traffic, redirects and stray responses
        set_knobs(1, 4, 70, 60, 3, 5);
        repeat (3000) step();

        // Asynchronous reset with a full queue
        set_knobs(2, 2, 100, 0, 0, 0);
        force_redir = 1'b1; force_addr = 32'h0000_0400;
        repeat (12) step();
        @(negedge clk);
        drive_idle();
        #2 rst = 1'b1;
        #1;
        check("f_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("f_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("f_rst_req_addr", bus.imem_req_addr, START);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        set_knobs(1, 3, 100, 100, 0, 0);
        wait_first_pop("f_first_pc", START);
        repeat (40) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
